// File: rtl/btn_debounce_toggle_gen.sv
// rtl/btn_debounce_toggle_gen.sv - pushbutton synchroniser, debouncer and toggle-pulse generator
module btn_debounce_toggle_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       enable,
  output logic       t_pulse,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   t_pulse_q, t_pulse_d;
  logic                   btn_level_q, btn_level_d;
  logic [7:0]             press_count_q, press_count_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], btn_in};

  // A level change is accepted only after the counter sees an unbroken run;
  // any opposite sample during a wait drops straight back to the idle state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    t_pulse_d     = 1'b0;
    btn_level_d   = btn_level_q;
    press_count_d = press_count_q;
    case (state_q)
      IDLE_LOW: begin
        if (sync_out) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_out) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = IDLE_HIGH;
          cnt_d       = '0;
          btn_level_d = 1'b1;
          t_pulse_d   = enable;
          if (enable) begin
            press_count_d = press_count_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync_out) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_out) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = IDLE_LOW;
          cnt_d       = '0;
          btn_level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= '0;
      state_q       <= IDLE_LOW;
      cnt_q         <= '0;
      t_pulse_q     <= 1'b0;
      btn_level_q   <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      t_pulse_q     <= t_pulse_d;
      btn_level_q   <= btn_level_d;
      press_count_q <= press_count_d;
    end
  end

  assign t_pulse     = t_pulse_q;
  assign btn_level   = btn_level_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_btn_debounce_toggle_gen.sv
// tb/tb_btn_debounce_toggle_gen.sv - self-checking bench for btn_debounce_toggle_gen
module tb_btn_debounce_toggle_gen;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       enable;
  logic       t_pulse;
  logic       btn_level;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  // Reference: btn_in delayed SYNC edges, accepted once DEB+1 consecutive
  // samples disagree with the current debounced level.
  logic       m_hist [SYNC];
  logic       m_level = 1'b0;
  logic       m_pulse = 1'b0;
  logic [7:0] m_count = 8'd0;
  int         m_run   = 0;

  logic prev_pulse  = 1'b0;
  logic tq          = 1'b0;
  int   pulse_total = 0;
  int   p0;
  int   len;

  always #5 clk = ~clk;

  btn_debounce_toggle_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .enable     (enable),
    .t_pulse    (t_pulse),
    .btn_level  (btn_level),
    .press_count(press_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic s;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
      m_level = 1'b0;
      m_pulse = 1'b0;
      m_count = 8'd0;
      m_run   = 0;
    end else begin
      s = m_hist[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = btn_in;
      m_pulse = 1'b0;
      if (s != m_level) m_run++;
      else m_run = 0;
      if (m_run == DEB + 1) begin
        m_level = s;
        m_run   = 0;
        if (m_level && enable) begin
          m_pulse = 1'b1;
          m_count = m_count + 8'd1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_t_pulse", t_pulse, m_pulse);
    chk("model_btn_level", btn_level, m_level);
    chk("model_press_count", press_count, m_count);
    chk("pulse_back_to_back", prev_pulse & t_pulse, 1'b0);
    prev_pulse = t_pulse;
    if (t_pulse) begin
      tq = ~tq;
      pulse_total++;
    end
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
    reset  = 1'b1;
    btn_in = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    chk("reset_t_pulse", t_pulse, 1'b0);
    chk("reset_btn_level", btn_level, 1'b0);
    chk("reset_press_count", press_count, 8'd0);
    reset = 1'b0;
    tick();

    // clean press: pulse exactly after edge 7
    btn_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("clean_t_pulse", t_pulse, (i == 7));
      chk("clean_btn_level", btn_level, (i >= 7));
    end
    chk("clean_press_count", press_count, 8'd1);
    repeat (3) tick();

    // release: level falls after edge 7, no pulse
    btn_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("release_btn_level", btn_level, (i < 7));
      chk("release_t_pulse", t_pulse, 1'b0);
    end
    chk("release_press_count", press_count, 8'd1);
    repeat (3) tick();

    // bounce: 3 high, 1 low, then stable high
    p0 = pulse_total;
    btn_in = 1'b1;
    repeat (3) tick();
    btn_in = 1'b0;
    tick();
    btn_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("bounce_t_pulse", t_pulse, (i == 7));
    end
    chk("bounce_pulse_total", pulse_total - p0, 1);
    chk("bounce_press_count", press_count, 8'd2);
    btn_in = 1'b0;
    repeat (10) tick();

    // disabled press, then enable raised while still held
    p0 = pulse_total;
    enable = 1'b0;
    btn_in = 1'b1;
    repeat (10) tick();
    chk("disabled_btn_level", btn_level, 1'b1);
    enable = 1'b1;
    repeat (10) tick();
    chk("disabled_pulse_total", pulse_total - p0, 0);
    chk("disabled_press_count", press_count, 8'd2);
    btn_in = 1'b0;
    repeat (10) tick();

    // reset in WAIT_HIGH with counter at 2, button held through reset
    btn_in = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("midreset_t_pulse", t_pulse, 1'b0);
    chk("midreset_btn_level", btn_level, 1'b0);
    chk("midreset_press_count", press_count, 8'd0);
    reset = 1'b0;
    p0 = pulse_total;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("midreset_t_pulse_after", t_pulse, (i == 7));
    end
    chk("midreset_pulse_total", pulse_total - p0, 1);
    chk("midreset_press_count_after", press_count, 8'd1);
    btn_in = 1'b0;
    repeat (10) tick();

    // wrap: 256 presses, downstream T-FF returns to 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tq = 1'b0;
    p0 = pulse_total;
    repeat (256) begin
      btn_in = 1'b1;
      repeat (9) tick();
      btn_in = 1'b0;
      repeat (9) tick();
    end
    chk("wrap_pulse_total", pulse_total - p0, 256);
    chk("wrap_press_count", press_count, 8'd0);
    chk("wrap_tff_q", tq, 1'b0);

    // random runs of input levels, enable changes and occasional resets
    repeat (300) begin
      btn_in = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      len = $urandom_range(1, 12);
      repeat (len) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
